gin_bus_sequencer: RTL and testbench
====================================

// Module: gin_bus_sequencer
// PURPOSE
//  Sequencer in front of one gin_bus. Programs the bus's multicast-controller
//  tag-ID scan chain from a small config table, then streams a fixed number of
//  tagged data words from an upstream valid/ready source onto the bus.
//  Upstream: layer scheduler/buffer. Downstream: gin_bus
//  (program, scan_tag_in, bus_enable, tag, data_source, bus_ready).
// PARAMETERS
//  BITWIDTH         16  data word width
//  TAG_LENGTH       4   tag / tag-ID width
//  NUM_CONTROLLERS  10  multicast controllers on the bus (scan-chain length)
//  CNT_WIDTH        16  width of packet counters and num_packets
//  (localparam AW = max(1, $clog2(NUM_CONTROLLERS)))
// PORTS
//  clk          in   1           clock
//  rstb         in   1           async active-low reset
//  start        in   1           1-cycle pulse: begin program+stream; ignored unless IDLE
//  abort        in   1           sync: return to IDLE from any state
//  num_packets  in   CNT_WIDTH   words to stream; sampled on accepted start
//  cfg_addr     out  AW          config-table index being shifted
//  cfg_tag      in   TAG_LENGTH  tag ID at cfg_addr (combinational table read)
//  in_valid     in   1           upstream word valid
//  in_ready     out  1           upstream word accepted when in_valid&in_ready
//  in_data      in   BITWIDTH    upstream data word
//  in_tag       in   TAG_LENGTH  upstream destination tag
//  program      out  1           gin_bus scan-chain shift enable
//  scan_tag_in  out  TAG_LENGTH  tag ID shifted into gin_bus
//  bus_enable   out  1           gin_bus word valid
//  bus_ready    in   1           gin_bus ready; transfer = bus_enable&bus_ready
//  tag          out  TAG_LENGTH  tag driven to gin_bus
//  data_source  out  BITWIDTH    data driven to gin_bus
//  busy         out  1           high in any state except IDLE
//  done         out  1           1-cycle pulse, all packets transferred
// BEHAVIOUR
//  - Reset (rstb=0, async): state IDLE; all outputs and counters 0.
//  - FSM IDLE -> PROGRAM -> SETTLE -> STREAM -> DONE -> IDLE.
//  - IDLE: start=1 -> PROGRAM. Load shift index = NUM_CONTROLLERS-1;
//    latch num_packets; clear sent/accepted counters.
//  - PROGRAM: program=1, cfg_addr=shift index, scan_tag_in=cfg_tag (comb).
//    Index decrements each cycle. Exactly NUM_CONTROLLERS cycles, index
//    N-1..0, so table entry 0 ends in the controller nearest the chain input.
//    After index 0 -> SETTLE.
//  - SETTLE: 1 cycle. program=0, bus_enable=0. Then: latched num_packets==0
//    -> DONE, else -> STREAM.
//  - STREAM: one-entry registered output stage (data_source/tag/bus_enable).
//    in_ready = (accepted < num_packets) && (!bus_enable || bus_ready).
//    Upstream accept loads stage next cycle (bus_enable=1).
//    Transfer without new accept clears bus_enable. Back-to-back gives 1 word/clk.
//    bus_ready=0 with bus_enable=1: tag/data_source held stable, no accept.
//    Never accepts more than num_packets words.
//    Transfer making sent==num_packets -> DONE. bus_enable is 0 the next cycle.
//  - DONE: done=1 for 1 cycle, busy=1 -> IDLE.
//  - Outside PROGRAM: program=0 and scan_tag_in=0.
//    Outside STREAM: bus_enable=0 and in_ready=0.
//  - start while busy: ignored. start and abort in the same cycle: abort wins.
//  - abort: next state IDLE. Clears bus_enable, program and counters.
//    No done pulse. A held word is dropped.
//  - Counters are CNT_WIDTH wide and unsigned. num_packets=2^CNT_WIDTH-1 is legal.
//  - Mid-operation reset: same as reset. The gin_bus must be reprogrammed.
// TESTING
//  1 Program: cfg table[i]=i+3, start -> program high exactly 10 cycles,
//    scan_tag_in = 12,11,...,3; then gin_bus mc[k] tag_id_reg == k+3.
//  2 Stream: num_packets=3, words (13,tag3),(11,tag1),(19,tag9), bus_ready=1,
//    in_valid=1 -> 3 consecutive bus_enable cycles in order, done pulses once.
//  3 Backpressure: bus_ready=0 for 4 cycles mid-stream -> data_source/tag
//    stable, in_ready=0, no loss or duplication once bus_ready returns.
//  4 Limits: num_packets=0 -> done 1 cycle after SETTLE, no bus_enable.
//    in_valid held high after 5 of 5 accepted -> in_ready stays 0.
//  5 abort during PROGRAM (cycle 4) and during STREAM -> IDLE next cycle,
//    program/bus_enable=0, no done. A following start reruns the full sequence.
//  6 rstb low mid-STREAM -> all outputs 0 immediately. start while busy ignored.

Source files
------------

// File: rtl/gin_bus_sequencer_if.sv
// Bundle of the upstream word handshake and the gin_bus control/data lines.
// The master modport is the sequencer; the slave modport is the combined
// upstream source plus gin_bus side.
interface gin_bus_sequencer_if #(
  parameter int BITWIDTH   = 16,
  parameter int TAG_LENGTH = 4
);
  // Upstream valid/ready word source
  logic                  in_valid;
  logic                  in_ready;
  logic [BITWIDTH-1:0]   in_data;
  logic [TAG_LENGTH-1:0] in_tag;

  // gin_bus scan-chain programming ("program" is a reserved word, hence program_en)
  logic                  program_en;
  logic [TAG_LENGTH-1:0] scan_tag_in;

  // gin_bus data path
  logic                  bus_enable;
  logic                  bus_ready;
  logic [TAG_LENGTH-1:0] tag;
  logic [BITWIDTH-1:0]   data_source;

  modport master (
    input  in_valid, in_data, in_tag, bus_ready,
    output in_ready, program_en, scan_tag_in, bus_enable, tag, data_source
  );

  modport slave (
    output in_valid, in_data, in_tag, bus_ready,
    input  in_ready, program_en, scan_tag_in, bus_enable, tag, data_source
  );
endinterface

// File: rtl/gin_bus_sequencer.sv
// Sequencer for one gin_bus: shifts the multicast-controller tag IDs from a
// config table into the bus scan chain (last entry first), waits one settle
// cycle, then streams num_packets tagged words from upstream through a
// one-entry registered output stage, and pulses done when the last word has
// been taken by the bus.
module gin_bus_sequencer #(
  parameter  int BITWIDTH        = 16,
  parameter  int TAG_LENGTH      = 4,
  parameter  int NUM_CONTROLLERS = 10,
  parameter  int CNT_WIDTH       = 16,
  localparam int AW              = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_WIDTH-1:0]  num_packets_i,
  output logic [AW-1:0]         cfg_addr_o,
  input  logic [TAG_LENGTH-1:0] cfg_tag_i,
  output logic                  busy_o,
  output logic                  done_o,
  gin_bus_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROGRAM,
    S_SETTLE,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CONTROLLERS - 1);

  state_t                state_q,  state_d;
  logic [AW-1:0]         idx_q,    idx_d;
  logic [CNT_WIDTH-1:0]  num_q,    num_d;
  logic [CNT_WIDTH-1:0]  sent_q,   sent_d;
  logic [CNT_WIDTH-1:0]  acc_q,    acc_d;
  logic                  bus_en_q, bus_en_d;
  logic [BITWIDTH-1:0]   data_q,   data_d;
  logic [TAG_LENGTH-1:0] tag_q,    tag_d;

  logic in_ready;
  logic accept;
  logic xfer;

  // Upstream is offered a slot only while streaming, below the word budget,
  // with the output stage free or draining this cycle. Abort also masks it so
  // an upstream word is never handshaken and then silently thrown away.
  assign in_ready = (state_q == S_STREAM) && !abort_i && (acc_q < num_q) &&
                    (!bus_en_q || bus.bus_ready);
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = bus_en_q && bus.bus_ready;

  // Next-state and datapath update logic for the whole sequencer
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    sent_d   = sent_q;
    acc_d    = acc_q;
    bus_en_d = bus_en_q;
    data_d   = data_q;
    tag_d    = tag_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_PROGRAM;
          idx_d   = LAST_IDX;
          num_d   = num_packets_i;
          sent_d  = '0;
          acc_d   = '0;
        end
      end

      // Table entry N-1 goes in first so entry 0 lands nearest the chain input
      S_PROGRAM: begin
        if (idx_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          idx_d = idx_q - AW'(1);
        end
      end

      S_SETTLE: begin
        state_d = (num_q == '0) ? S_DONE : S_STREAM;
      end

      S_STREAM: begin
        if (accept) begin
          bus_en_d = 1'b1;
          data_d   = bus.in_data;
          tag_d    = bus.in_tag;
          acc_d    = acc_q + CNT_WIDTH'(1);
        end else if (xfer) begin
          bus_en_d = 1'b0;
        end
        if (xfer) begin
          sent_d = sent_q + CNT_WIDTH'(1);
          // num_q is non-zero here, so num_q-1 cannot wrap
          if (sent_q == num_q - CNT_WIDTH'(1)) begin
            state_d  = S_DONE;
            bus_en_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort has priority over everything, including a same-cycle start
    if (abort_i) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      num_d    = '0;
      sent_d   = '0;
      acc_d    = '0;
      bus_en_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      sent_q   <= '0;
      acc_q    <= '0;
      bus_en_q <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      sent_q   <= sent_d;
      acc_q    <= acc_d;
      bus_en_q <= bus_en_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end

  // Scan-chain outputs are only live during PROGRAM
  assign bus.program_en  = (state_q == S_PROGRAM);
  assign cfg_addr_o      = (state_q == S_PROGRAM) ? idx_q : '0;
  assign bus.scan_tag_in = (state_q == S_PROGRAM) ? cfg_tag_i : '0;

  assign bus.in_ready    = in_ready;
  assign bus.bus_enable  = bus_en_q;
  assign bus.tag         = tag_q;
  assign bus.data_source = data_q;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_gin_bus_sequencer.sv
// Self-checking bench for gin_bus_sequencer: models the config table and the
// gin_bus scan chain, and scoreboards every upstream word against the bus.
module tb_gin_bus_sequencer;

  localparam int BW = 16;
  localparam int TL = 4;
  localparam int NC = 10;
  localparam int CW = 16;
  localparam int AW = 4;

  typedef logic [TL+BW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_packets = '0;
  logic [AW-1:0] cfg_addr;
  logic [TL-1:0] cfg_tag;
  logic          busy;
  logic          done;

  gin_bus_sequencer_if #(.BITWIDTH(BW), .TAG_LENGTH(TL)) bus ();

  gin_bus_sequencer #(
    .BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(NC), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .start_i       (start),
    .abort_i       (abort),
    .num_packets_i (num_packets),
    .cfg_addr_o    (cfg_addr),
    .cfg_tag_i     (cfg_tag),
    .busy_o        (busy),
    .done_o        (done),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Config table: entry i holds tag ID i+3
  assign cfg_tag = TL'(cfg_addr) + TL'(3);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  word_t         src_q[$];
  word_t         sb_q[$];
  logic [TL-1:0] chain [NC];
  logic          acc_seen = 1'b0;
  logic [CW-1:0] exp_num = '0;
  int n_prog = 0, n_busy = 0, n_xfer = 0, n_done = 0, n_acc = 0, n_bus_en = 0;
  int cyc = 0, first_xfer = 0, last_xfer = 0, done_at = 0;

  // Monitor: samples on the falling edge, models the scan chain, scoreboards
  always @(negedge clk) begin
    cyc++;
    if (!rstb) begin
      acc_seen = 1'b0;
    end else begin
      acc_seen = bus.in_valid && bus.in_ready;
      if (busy) n_busy++;
      if (bus.program_en) begin
        check("scan_tag", 32'(bus.scan_tag_in), 32'(12 - n_prog));
        for (int k = NC - 1; k > 0; k--) chain[k] = chain[k-1];
        chain[0] = bus.scan_tag_in;
        n_prog++;
      end
      if (bus.bus_enable) n_bus_en++;
      if (bus.bus_enable && !bus.bus_ready) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'(0));
        if (sb_q.size() > 0) check("stall_word", 32'({bus.tag, bus.data_source}), 32'(sb_q[0]));
      end
      if (busy && n_acc == int'(exp_num))
        check("limit_in_ready", 32'(bus.in_ready), 32'(0));
      if (bus.bus_enable && bus.bus_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'(1), 32'(0));
        else check("bus_word", 32'({bus.tag, bus.data_source}), 32'(sb_q.pop_front()));
        if (n_xfer == 0) first_xfer = cyc;
        last_xfer = cyc;
        n_xfer++;
      end
      if (acc_seen) begin
        sb_q.push_back({bus.in_tag, bus.in_data});
        n_acc++;
      end
      if (done) begin
        n_done++;
        done_at = n_busy;
      end
    end
  end

  // Upstream source: presents the head of src_q, advances after a handshake
  always @(posedge clk) begin
    #1;
    if (acc_seen && src_q.size() > 0) void'(src_q.pop_front());
    bus.in_valid = (src_q.size() > 0);
    {bus.in_tag, bus.in_data} = (src_q.size() > 0) ? src_q[0] : '0;
  end

  task automatic pulse_start(input logic [CW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_packets = n; exp_num = n;
    n_prog = 0; n_busy = 0; n_xfer = 0; n_done = 0; n_acc = 0; n_bus_en = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && n_done == 0; i++) @(negedge clk);
    check("done_seen", 32'(n_done != 0), 32'(1));
    repeat (3) @(negedge clk);
    check("done_once", 32'(n_done), 32'(1));
    check("idle_after", 32'(busy), 32'(0));
  endtask

  task automatic wait_xfer(input int n);
    for (int i = 0; i < 200 && n_xfer < n; i++) @(posedge clk);
    check("xfer_reached", 32'(n_xfer >= n), 32'(1));
  endtask

  task automatic check_chain();
    for (int k = 0; k < NC; k++) check("chain", 32'(chain[k]), 32'(k + 3));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"},    32'(busy),            32'(0));
    check({name, "_done"},    32'(done),            32'(0));
    check({name, "_program"}, 32'(bus.program_en),  32'(0));
    check({name, "_scan"},    32'(bus.scan_tag_in), 32'(0));
    check({name, "_cfgaddr"}, 32'(cfg_addr),        32'(0));
    check({name, "_bus_en"},  32'(bus.bus_enable),  32'(0));
    check({name, "_inrdy"},   32'(bus.in_ready),    32'(0));
    check({name, "_tag"},     32'(bus.tag),         32'(0));
    check({name, "_data"},    32'(bus.data_source), 32'(0));
  endtask

  task automatic push_words(input int n, input int seed);
    for (int i = 0; i < n; i++)
      src_q.push_back({TL'(seed + i), BW'(16'h1000 + seed * 37 + i * 11)});
  endtask

  task automatic quiet_no_done(input string name);
    repeat (5) @(negedge clk);
    check({name, "_no_done"}, 32'(n_done), 32'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.bus_ready = 1'b1;
    for (int k = 0; k < NC; k++) chain[k] = '0;

    // Reset state
    #12;
    check_quiet("reset");
    @(posedge clk); #1 rstb = 1'b1;

    // Program + basic stream of three words
    src_q.push_back({4'd3, 16'd13});
    src_q.push_back({4'd1, 16'd11});
    src_q.push_back({4'd9, 16'd19});
    pulse_start(16'd3);
    wait_done(100);
    check("t2_prog_cycles", 32'(n_prog), 32'(10));
    check_chain();
    check("t2_xfers", 32'(n_xfer), 32'(3));
    check("t2_back_to_back", 32'(last_xfer - first_xfer), 32'(2));
    check("t2_sb_empty", 32'(sb_q.size()), 32'(0));

    // Backpressure for four cycles mid-stream
    push_words(6, 2);
    pulse_start(16'd6);
    wait_xfer(2);
    #1 bus.bus_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.bus_ready = 1'b1;
    wait_done(200);
    check("t3_xfers", 32'(n_xfer), 32'(6));
    check("t3_accepts", 32'(n_acc), 32'(6));
    check("t3_sb_empty", 32'(sb_q.size()), 32'(0));

    // Zero packets: done right after SETTLE, bus never enabled
    pulse_start(16'd0);
    wait_done(100);
    check("t4_done_cycle", 32'(done_at), 32'(12));
    check("t4_no_bus_en", 32'(n_bus_en), 32'(0));

    // Word budget: seven words offered, five taken
    push_words(7, 5);
    pulse_start(16'd5);
    wait_done(200);
    check("t4_accepts", 32'(n_acc), 32'(5));
    check("t4_xfers", 32'(n_xfer), 32'(5));
    check("t4_valid_left", 32'(bus.in_valid), 32'(1));
    check("t4_ready_low", 32'(bus.in_ready), 32'(0));
    src_q.delete();
    repeat (2) @(posedge clk);

    // Abort in the fourth PROGRAM cycle, then a full rerun
    pulse_start(16'd4);
    for (int i = 0; i < 50 && n_prog < 4; i++) @(negedge clk);
    check("t5_prog_reached", 32'(n_prog), 32'(4));
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t5a_busy", 32'(busy), 32'(0));
    check("t5a_program", 32'(bus.program_en), 32'(0));
    quiet_no_done("t5a");
    push_words(4, 7);
    pulse_start(16'd4);
    wait_done(200);
    check("t5a_rerun_prog", 32'(n_prog), 32'(10));
    check("t5a_rerun_xfers", 32'(n_xfer), 32'(4));
    check_chain();

    // Abort while a word is held on a stalled bus
    push_words(6, 9);
    bus.bus_ready = 1'b0;
    pulse_start(16'd6);
    for (int i = 0; i < 50 && n_bus_en == 0; i++) @(negedge clk);
    check("t5b_held", 32'(bus.bus_enable), 32'(1));
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t5b_busy", 32'(busy), 32'(0));
    check("t5b_bus_en", 32'(bus.bus_enable), 32'(0));
    check("t5b_inrdy", 32'(bus.in_ready), 32'(0));
    quiet_no_done("t5b");
    src_q.delete();
    sb_q.delete();
    bus.bus_ready = 1'b1;
    repeat (2) @(posedge clk);
    push_words(3, 4);
    pulse_start(16'd3);
    wait_done(200);
    check("t5b_rerun_xfers", 32'(n_xfer), 32'(3));
    check("t5b_rerun_prog", 32'(n_prog), 32'(10));

    // Start while busy is ignored
    push_words(8, 1);
    pulse_start(16'd8);
    wait_xfer(3);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);
    check("t6_xfers", 32'(n_xfer), 32'(8));
    check("t6_prog", 32'(n_prog), 32'(10));
    repeat (4) @(negedge clk);
    check("t6_stays_idle", 32'(busy), 32'(0));

    // Reset mid-stream clears outputs without waiting for a clock
    push_words(8, 3);
    pulse_start(16'd8);
    wait_xfer(3);
    #3 rstb = 1'b0;
    #1 check_quiet("midrst");
    src_q.delete();
    sb_q.delete();
    @(posedge clk); #1 rstb = 1'b1;
    push_words(2, 6);
    pulse_start(16'd2);
    wait_done(200);
    check("t6_rst_rerun_prog", 32'(n_prog), 32'(10));
    check("t6_rst_rerun_xfers", 32'(n_xfer), 32'(2));
    check_chain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
